// File: rtl/wfg_ram_pkg.sv
// Shared definitions for the waveform-generator sample RAM reader.
//   WFG_DATA_WIDTH / WFG_ADDR_WIDTH : default RAM word and address widths
//   rd_state_e                      : reader sequencing states
package wfg_ram_pkg;

    localparam int unsigned WFG_DATA_WIDTH = 32;
    localparam int unsigned WFG_ADDR_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/wfg_ram_reader_fifo.sv
// Two-entry first-word-fall-through FIFO with synchronous flush.
// The head entry is its own register, so the head output comes straight off a flop.
//   clk, rst_n : clock, async active-low reset
//   flush      : drop all entries at the next edge (wins over push/pop)
//   push/push_data : write one entry
//   pop        : consume the head entry (only when valid)
//   head       : current head entry
//   valid      : FIFO not empty
//   count      : number of stored entries (0..2)
module wfg_ram_reader_fifo #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             valid_q, valid_d;

    // Next-state: shift tail into head on pop, land pushes in the first free slot.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = push_data;
                    else                 tail_d = push_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = push_data;
                    end else begin
                        head_d = push_data;
                    end
                end
                default: ;
            endcase
        end
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign head  = head_q;
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/wfg_ram_reader.sv
// Read-side initiator for the 1RW1R sample RAM: walks [start_addr..end_addr]
// (wrapping through the top of memory when end < start) and streams the words
// out as valid/ready, buffering up to two words against backpressure.
// Optional build macro WFG_RAM_READER_LOOP_EN: replay the window continuously
// until enable drops, instead of a single pass per enable.
//   clk, rst_n           : clock (also the RAM clk1), async active-low reset
//   enable               : 1 = run, 0 = abort / stay idle
//   start_addr, end_addr : inclusive address window, sampled when a pass starts
//   busy                 : not idle
//   done                 : high in the cycle the last word of a pass is accepted
//   csb1, addr1, dout1   : RAM read port (csb1 active low)
//   m_data, m_valid, m_ready : output stream
module wfg_ram_reader
    import wfg_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WFG_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = WFG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    // FIFO entries carry a "last word of window" tag above the data.
    localparam int unsigned FIFO_WIDTH = DATA_WIDTH + 1;

    rd_state_e             state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  csb1_q, csb1_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
`ifdef WFG_RAM_READER_LOOP_EN
    logic [ADDR_WIDTH-1:0] start_q, start_d;
`endif
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;

    logic                  flush, push, pop, head_last, done_c;
    logic [FIFO_WIDTH-1:0] head;
    logic                  fifo_valid;
    logic [1:0]            fifo_count;
    logic [2:0]            occupancy;

    wfg_ram_reader_fifo #(.WIDTH(FIFO_WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data ({inflight_last_q, dout1}),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign pop       = fifo_valid && m_ready;
    assign flush     = !enable && (state_q != IDLE);
    assign push      = inflight_q && !flush;
    assign head_last = head[FIFO_WIDTH-1];
    // Slots committed after this edge; a pop this cycle frees its slot in time
    // for a read issued now, which keeps the stream at one word per cycle.
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign done_c    = pop && head_last && enable && (state_q != IDLE);

    // Sequencing, read issue and window address generation.
    always_comb begin
        state_d         = state_q;
        csb1_d          = 1'b1;
        addr1_d         = addr1_q;
        next_addr_d     = next_addr_q;
        end_d           = end_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
`ifdef WFG_RAM_READER_LOOP_EN
        start_d         = start_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d     = RUN;
                    next_addr_d = start_addr;
                    end_d       = end_addr;
`ifdef WFG_RAM_READER_LOOP_EN
                    start_d     = start_addr;
`endif
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (occupancy < 3'd2) begin
                    csb1_d      = 1'b0;
                    addr1_d     = next_addr_q;
                    inflight_d  = 1'b1;
                    next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    if (next_addr_q == end_q) begin
                        inflight_last_d = 1'b1;
`ifdef WFG_RAM_READER_LOOP_EN
                        next_addr_d = start_q;
`else
                        state_d     = DRAIN;
`endif
                    end
                end
            end
            DRAIN: begin
                // The tagged word is the last one issued, so its acceptance
                // means nothing is in flight and the FIFO empties.
                if (!enable || done_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            csb1_q          <= 1'b1;
            addr1_q         <= '0;
            next_addr_q     <= '0;
            end_q           <= '0;
`ifdef WFG_RAM_READER_LOOP_EN
            start_q         <= '0;
`endif
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            csb1_q          <= csb1_d;
            addr1_q         <= addr1_d;
            next_addr_q     <= next_addr_d;
            end_q           <= end_d;
`ifdef WFG_RAM_READER_LOOP_EN
            start_q         <= start_d;
`endif
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    assign busy    = busy_q;
    assign csb1    = csb1_q;
    assign addr1   = addr1_q;
    assign m_valid = fifo_valid;
    assign m_data  = head[DATA_WIDTH-1:0];
    assign done    = done_c;

endmodule

// File: tb/tb_wfg_ram_reader.sv
// Directed bench for wfg_ram_reader with a behavioural read-port RAM model
// (data driven at the falling edge after the address is presented).
module tb_wfg_ram_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          busy;
    logic          done;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;

    logic [DW-1:0] mem [64];
    int            n_cmp;
    int            n_bad;

    wfg_ram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .busy       (busy),
        .done       (done),
        .csb1       (csb1),
        .addr1      (addr1),
        .dout1      (dout1),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!csb1) dout1 <= mem[addr1];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Runs one window and checks the delivered stream. Starts and ends just after
    // a rising edge. abort_after != 0 returns at the falling edge where that many
    // words have been accepted, with enable still high.
    task automatic run_window(input int s, input int e_addr, input int nwords,
                              input bit toggle, input bit strict, input int abort_after);
        int          len, got, cyc, ph, issued, dones, first_cyc, last_cyc;
        bit          stalled, aborted;
        logic [31:0] held, exp_word;
        len        = ((e_addr - s) & 63) + 1;
        start_addr = AW'(s);
        end_addr   = AW'(e_addr);
        enable     = 1'b1;
        m_ready    = 1'b1;
        got = 0; cyc = 0; ph = 0; issued = 0; dones = 0; first_cyc = 0; last_cyc = 0;
        stalled = 1'b0; aborted = 1'b0; held = '0;
        while (got < nwords && cyc < 400 && !aborted) begin
            if (toggle) begin
                m_ready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end
            @(negedge clk);
            if (!csb1) issued++;
            check_val("credit", 32'(issued - got <= 2), 32'd1);
            if (stalled) check_val("stall_hold", m_data, held);
            if (m_valid && m_ready) begin
                exp_word = 32'hA000_0000 + 32'((s + (got % len)) % 64);
                check_val("word", m_data, exp_word);
                check_val("done_on_word", 32'(done), 32'((got % len) == len - 1));
                if (done) dones++;
                if (got == 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end else begin
                check_val("done_idle", 32'(done), 32'd0);
            end
            stalled = m_valid && !m_ready;
            held    = m_data;
            if (abort_after != 0 && got == abort_after) begin
                aborted = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!aborted) begin
            check_val("words", 32'(got), 32'(nwords));
            check_val("done_count", 32'(dones), 32'(nwords / len));
            if (strict && !toggle) check_val("back_to_back", 32'(last_cyc - first_cyc), 32'(nwords - 1));
            enable  = 1'b0;
            m_ready = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (!csb1) issued++;
            end
            if (strict) check_val("issue_count", 32'(issued), 32'(nwords));
            check_val("idle_busy", 32'(busy), 32'd0);
            check_val("idle_valid", 32'(m_valid), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        rst_n      = 1'b0;
        enable     = 1'b0;
        m_ready    = 1'b0;
        start_addr = '0;
        end_addr   = '0;

        // Reset state
        #12;
        check_val("rst_busy",   32'(busy),    32'd0);
        check_val("rst_done",   32'(done),    32'd0);
        check_val("rst_csb1",   32'(csb1),    32'd1);
        check_val("rst_addr1",  32'(addr1),   32'd0);
        check_val("rst_mvalid", 32'(m_valid), 32'd0);
        check_val("rst_mdata",  m_data,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_window(4, 7, 4, 1'b0, 1'b1, 0);
        run_window(62, 1, 4, 1'b0, 1'b1, 0);
        run_window(10, 10, 1, 1'b0, 1'b1, 0);
        run_window(0, 15, 16, 1'b1, 1'b1, 0);

        // Abort after the third accepted word, then a fresh pass from start
        run_window(0, 15, 16, 1'b0, 1'b1, 3);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(negedge clk);
        check_val("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check_val("abort_mvalid", 32'(m_valid), 32'd0);
        check_val("abort_csb1",   32'(csb1),    32'd1);
        check_val("abort_busy",   32'(busy),    32'd0);
        check_val("abort_done",   32'(done),    32'd0);
        @(negedge clk);
        check_val("abort_stay_csb1", 32'(csb1), 32'd1);
        check_val("abort_stay_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        run_window(0, 15, 16, 1'b0, 1'b1, 0);

        // enable held: single-pass restarts and loop mode both give 2,3,2,3,...
        run_window(2, 3, 6, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of a stalled pass
        start_addr = AW'(0);
        end_addr   = AW'(15);
        enable     = 1'b1;
        m_ready    = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_val("pre_rst_mvalid", 32'(m_valid), 32'd1);
        check_val("pre_rst_mdata",  m_data,       32'hA000_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_busy",   32'(busy),    32'd0);
        check_val("arst_done",   32'(done),    32'd0);
        check_val("arst_csb1",   32'(csb1),    32'd1);
        check_val("arst_addr1",  32'(addr1),   32'd0);
        check_val("arst_mvalid", 32'(m_valid), 32'd0);
        check_val("arst_mdata",  m_data,       32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
